// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester (apb_master_ctrl) and the APB
// slave (apb_s).
//   apb_state_e      : requester FSM state encoding (IDLE / SETUP / ACCESS)
//   APB_ADDR_W       : default address width
//   APB_DATA_W       : default data width
//   APB_TO_CNT_W     : width of the optional ACCESS wait-state counter
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W   = 4;
  localparam int APB_DATA_W   = 8;
  localparam int APB_TO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Wait-state counter for the requester's ACCESS phase. Only present in builds
// with APB_TIMEOUT_EN defined; in the default build this file contributes no
// module, so nothing dangles unused at the top of the hierarchy.
//   clk_i   : clock (rising edge)
//   rst_i   : asynchronous active-high reset
//   clr_i   : clear the count (asserted on the cycle that enters ACCESS)
//   inc_i   : count one ACCESS cycle in which the slave stalled
//   hit_o   : count has reached LIMIT-1 (combinational from the count)
// Parameter LIMIT: number of stalled ACCESS cycles allowed, 2..255.
// -----------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  logic [APB_TO_CNT_W-1:0] cnt_q;
  logic [APB_TO_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals the index of the current ACCESS cycle (0-based), so a
  // hit means this is the LIMIT-th ACCESS cycle.
  assign hit_o = (cnt_q == APB_TO_CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
// APB requester: accepts one command at a time, runs the SETUP/ACCESS
// transfer on the APB bus, holds ACCESS while the slave stalls, and returns a
// one-cycle response pulse.
//
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE and does not depend
// on cmd_valid; the requester must hold the command stable until it transfers.
// The response side has no back-pressure: rsp_valid is a single-cycle pulse.
//
// Ports:
//   pclk, preset               : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command interface
//   rsp_valid/rdata/err        : response pulse, read data, timeout flag
//   psel/penable/pwrite/paddr/pwdata : APB request outputs (all registered)
//   prdata/pready              : APB slave returns
//
// Build option APB_TIMEOUT_EN: abort a transfer after TIMEOUT_CYC ACCESS
// cycles without pready, returning rsp_err = 1. Without it ACCESS waits
// indefinitely and rsp_err is tied low.
// -----------------------------------------------------------------------------
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("apb_master_ctrl: TIMEOUT_CYC must be in 2..255");
  end

  apb_state_e          state_q,     state_d;
  logic                psel_q,      psel_d;
  logic                penable_q,   penable_d;
  logic                pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,     paddr_d;
  logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic to_hit;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk_i (pclk),
    .rst_i (preset),
    .clr_i (state_q == SETUP),
    .inc_i ((state_q == ACCESS) && !pready),
    .hit_o (to_hit)
  );
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    rsp_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        // pready is not looked at here; SETUP is always exactly one cycle.
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A pready arriving on the limit cycle takes priority over abort.
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
// Bench for apb_master_ctrl: a requester driver with a command queue, a slave
// model with per-transfer wait states and its own memory, and a transfer-level
// reference model (cycles since acceptance + reference memory) checked against
// every DUT output once per cycle on the falling edge. Directed transfers pin
// latency, wait-state, back-to-back, reset and timeout behaviour with literal
// values; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready;

  apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; int waits; int gap; } cmd_t;
  typedef struct { int acc; int rsp; int pen; logic [DW-1:0] rdata; logic err; } rec_t;

  cmd_t cmd_q[$];
  int   pend_wait_q[$];
  rec_t rec_q[$];
  int   gap_left    = 0;
  bit   pop_pending = 0;
  int   cur_acc     = 0;
  int   pen_cnt     = 0;

  // slave model
  logic [DW-1:0] slave_mem[16];
  int            cur_wait = 0;
  int            acc_cnt  = 0;

  // reference model: transfer progress counted in cycles since acceptance
  int            m_phase;            // 0 idle, 1 setup, >=2 access
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_rv, m_re;
  logic [DW-1:0] ref_mem[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_write = 0; m_addr = '0; m_wdata = '0;
    m_rdata = '0; m_rv = 0; m_re = 0;
  endtask

  // Advance the reference by one rising edge using the inputs now on the pins.
  task automatic model_step();
    m_rv = 0;
    m_re = 0;
    if (m_phase == 0) begin
      if (cmd_valid) begin
        m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (pready) begin
      if (m_write) begin
        ref_mem[m_addr] = m_wdata;
        m_rdata = '0;
      end else begin
        m_rdata = ref_mem[m_addr];
      end
      m_rv = 1;
      m_phase = 0;
    end
`ifdef APB_TIMEOUT_EN
    else if (m_phase - 2 == TO - 1) begin
      m_rv = 1; m_re = 1; m_rdata = '0;
      m_phase = 0;
    end
`endif
    else begin
      m_phase++;
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input int gap);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d; c.waits = waits; c.gap = gap;
    if (cmd_q.size() == 0 && !cmd_valid) gap_left = gap;
    cmd_q.push_back(c);
  endtask

  // One clock cycle: compare, record, drive requester and slave, step model.
  task automatic cycle();
    bit acc;
    @(negedge pclk);
    cyc++;
    chk("cmd_ready", cmd_ready, m_phase == 0);
    chk("psel",      psel,      m_phase >= 1);
    chk("penable",   penable,   m_phase >= 2);
    chk("pwrite",    pwrite,    m_write);
    chk("paddr",     paddr,     m_addr);
    chk("pwdata",    pwdata,    m_wdata);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_err",   rsp_err,   m_re);
    chk("rsp_rdata", rsp_rdata, m_rdata);

    if (penable === 1'b1) pen_cnt++;
    if (rsp_valid === 1'b1) rec_q.push_back('{cur_acc, cyc, pen_cnt, rsp_rdata, rsp_err});

    // requester
    if (pop_pending) begin
      cmd_valid = 0;
      pop_pending = 0;
    end
    if (!cmd_valid && cmd_q.size() > 0) begin
      if (gap_left > 0) begin
        gap_left--;
      end else begin
        cmd_valid = 1;
        cmd_write = cmd_q[0].wr;
        cmd_addr  = cmd_q[0].addr;
        cmd_wdata = cmd_q[0].data;
      end
    end

    // slave
    if (psel === 1'b1 && penable === 1'b0 && pend_wait_q.size() > 0) begin
      cur_wait = pend_wait_q.pop_front();
      acc_cnt  = 0;
    end
    if (psel === 1'b1 && penable === 1'b1) begin
      pready = (acc_cnt >= cur_wait);
      acc_cnt++;
    end else begin
      pready = 1'($urandom_range(0, 1));
    end
    if (pready && psel === 1'b1 && penable === 1'b1) begin
      prdata = slave_mem[paddr];
      if (pwrite === 1'b1) slave_mem[paddr] = pwdata;
    end else begin
      prdata = DW'($urandom);
    end

    acc = cmd_valid && (cmd_ready === 1'b1);
    model_step();
    if (acc) begin
      cmd_t c;
      c = cmd_q.pop_front();
      pend_wait_q.push_back(c.waits);
      cur_acc = cyc;
      pen_cnt = 0;
      pop_pending = 1;
      if (cmd_q.size() > 0) gap_left = cmd_q[0].gap;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (cmd_q.size() == 0 && !cmd_valid && m_phase == 0 && !pop_pending) break;
      cycle();
    end
    chk("drain_within_budget", i < budget, 1);
    repeat (2) cycle();
  endtask

  task automatic do_reset_pulse();
    #2 preset = 1;
    #1;
    chk("rst_psel",      psel,      0);
    chk("rst_penable",   penable,   0);
    chk("rst_rsp_valid", rsp_valid, 0);
    model_reset();
    cmd_valid = 0;
    cmd_q.delete();
    pend_wait_q.delete();
    pop_pending = 0;
    @(negedge pclk);
    #2 preset = 0;
  endtask

  initial begin
    int found;
    preset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = DW'(i * 13 + 7);
      ref_mem[i]   = DW'(i * 13 + 7);
    end
    model_reset();

    // reset values
    repeat (2) @(negedge pclk);
    chk("reset_psel",      psel,      0);
    chk("reset_penable",   penable,   0);
    chk("reset_pwrite",    pwrite,    0);
    chk("reset_paddr",     paddr,     0);
    chk("reset_pwdata",    pwdata,    0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err",   rsp_err,   0);
    #2 preset = 0;
    cycle();
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // write 0x3 <= 0xA5, no wait states
    rec_q.delete();
    push_cmd(1, 4'h3, 8'hA5, 0, 0);
    run_until_idle(50);
    chk("w_nowait_nrsp",    rec_q.size(), 1);
    chk("w_nowait_latency", rec_q[0].rsp - rec_q[0].acc, 3);
    chk("w_nowait_penable", rec_q[0].pen, 1);
    chk("w_nowait_err",     rec_q[0].err, 0);
    chk("w_nowait_mem3",    slave_mem[3], 8'hA5);

    // read 0x3 with 3 wait states
    rec_q.delete();
    push_cmd(0, 4'h3, 8'h00, 3, 1);
    run_until_idle(50);
    chk("r_wait3_nrsp",    rec_q.size(), 1);
    chk("r_wait3_latency", rec_q[0].rsp - rec_q[0].acc, 6);
    chk("r_wait3_penable", rec_q[0].pen, 4);
    chk("r_wait3_rdata",   rec_q[0].rdata, 8'hA5);

    // back-to-back write 0x7 <= 0x11, read 0x7
    rec_q.delete();
    push_cmd(1, 4'h7, 8'h11, 0, 0);
    push_cmd(0, 4'h7, 8'h00, 0, 0);
    run_until_idle(50);
    chk("b2b_nrsp",       rec_q.size(), 2);
    chk("b2b_accept_at",  rec_q[1].acc, rec_q[0].rsp);
    chk("b2b_read_rdata", rec_q[1].rdata, 8'h11);

    // reset while ACCESS is stalled
    rec_q.delete();
    push_cmd(0, 4'h5, 8'h00, 10, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (penable === 1'b1 && pready === 1'b0) found = 1;
    end
    chk("reached_stalled_access", found, 1);
    do_reset_pulse();
    repeat (6) cycle();
    chk("no_rsp_after_reset", rec_q.size(), 0);
    push_cmd(1, 4'h9, 8'h5C, 1, 0);
    push_cmd(0, 4'h9, 8'h00, 2, 0);
    run_until_idle(50);
    chk("post_reset_nrsp",  rec_q.size(), 2);
    chk("post_reset_rdata", rec_q[1].rdata, 8'h5C);

`ifdef APB_TIMEOUT_EN
    // abort after 16 stalled ACCESS cycles
    rec_q.delete();
    push_cmd(0, 4'h2, 8'h00, 40, 0);
    run_until_idle(100);
    chk("to_abort_nrsp",    rec_q.size(), 1);
    chk("to_abort_penable", rec_q[0].pen, 16);
    chk("to_abort_latency", rec_q[0].rsp - rec_q[0].acc, 18);
    chk("to_abort_err",     rec_q[0].err, 1);
    chk("to_abort_rdata",   rec_q[0].rdata, 0);
    // pready on exactly the 16th ACCESS cycle completes normally
    rec_q.delete();
    push_cmd(0, 4'h3, 8'h00, 15, 0);
    run_until_idle(100);
    chk("to_edge_nrsp",    rec_q.size(), 1);
    chk("to_edge_penable", rec_q[0].pen, 16);
    chk("to_edge_err",     rec_q[0].err, 0);
    chk("to_edge_rdata",   rec_q[0].rdata, 8'hA5);
`endif

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
`ifdef APB_TIMEOUT_EN
      push_cmd(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
               $urandom_range(0, 18), $urandom_range(0, 2));
`else
      push_cmd(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
               $urandom_range(0, 5), $urandom_range(0, 2));
`endif
    end
    run_until_idle(20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
